axi_ram_slave: RTL
==================

Name: axi_ram_slave

Overview:
- AXI3-style burst responder backed by an on-chip word RAM.
- It is the slave-side counterpart to the cache line-refill/write-back AXI master.
- Used as block-RAM main memory in FPGA builds and as the memory model in cache testbenches.
- Serves one transaction at a time (read or write burst) with FIXED/INCR/WRAP addressing, 32-bit data, byte strobes and ID echo.

Parameters:
- MEM_ADDR_LEN, 12, word-address bits; RAM depth 2^MEM_ADDR_LEN words of 32 bits.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be aligned to the RAM size.
- INIT_FILE, "", optional $readmemh image; empty means RAM powers up as zero.

Ports:
- aclk  in  1  clock; everything is rising-edge.
- aresetn  in  1  synchronous, active-low reset.
- arid/araddr/arlen/arsize/arburst  in  4/32/8/3/2  read address channel.
- arlock/arcache/arprot  in  2/4/3  accepted, ignored.
- arvalid  in  1;  arready  out  1.
- rid/rdata/rresp/rlast/rvalid  out  4/32/2/1/1  read data channel;  rready  in  1.
- awid/awaddr/awlen/awsize/awburst  in  4/32/8/3/2  write address channel.
- awlock/awcache/awprot  in  2/4/3  ignored.
- awvalid  in  1;  awready  out  1.
- wid/wdata/wstrb/wlast/wvalid  in  4/32/4/1/1  write data (wid ignored);  wready  out  1.
- bid/bresp/bvalid  out  4/2/1;  bready  in  1.
- protocol_err  out  1  sticky wlast-mismatch flag.

Behaviour:
- Reset (aresetn=0 at an edge):
  - FSM goes to IDLE; all ready/valid outputs, rlast, protocol_err, rid, bid, rresp, bresp and rdata go to 0.
  - RAM contents are preserved.
  - Reset mid-burst abandons the burst; beats already written stay written.
- FSM states: IDLE, RD, WR, WR_RESP.
- IDLE:
  - awready = 1.
  - arready = !awvalid (write wins a simultaneous request, giving read-after-write ordering).
  - AW handshake: latch awid/awaddr/awlen/awburst, clear beat count, go to WR.
  - AR handshake: latch the same fields from AR, issue the RAM read for beat 0 in the same cycle, go to RD.
- Beat size:
  - Every beat is 4 bytes; arsize/awsize are ignored.
  - Address bits [1:0] are ignored.
- Next-beat address:
  - FIXED: unchanged.
  - INCR: +4.
  - WRAP: +4 within a window of (len+1)*4 bytes aligned to that size; len must be 1, 3, 7 or 15, otherwise WRAP behaves as INCR.
  - Reserved burst type 2'b11 behaves as INCR.
- Range check:
  - Word is in range iff (addr - BASE_ADDR) >> 2 < 2^MEM_ADDR_LEN.
  - Out-of-range reads return rdata=0 with rresp=SLVERR (2'b10).
  - Out-of-range writes are dropped and the burst's bresp becomes SLVERR.
  - Otherwise resp is OKAY (2'b00).
- RD:
  - First beat: rvalid rises the cycle after the AR handshake.
  - rid = latched id; rlast = 1 only on beat len.
  - rdata/rvalid are held stable while rready = 0.
  - On an R handshake, the RAM read for the next beat uses the next address, so throughput is one beat per cycle with rready held high.
  - After the handshake of the final beat: rvalid = 0, return to IDLE; a new AR can be accepted the following cycle.
- WR:
  - wready = 1.
  - Each W handshake writes the bytes where wstrb[i] = 1 at the current address, then advances the address and count.
  - The burst ends on the handshake of beat awlen (count == awlen), regardless of wlast; go to WR_RESP.
- protocol_err sets (sticky until reset) if:
  - wlast = 1 on a non-final beat, or
  - wlast = 0 on the final beat.
- WR_RESP:
  - bvalid = 1, bid = latched id, bresp = accumulated response.
  - Held until bready; on the B handshake return to IDLE.
  - wready = 0 here, so extra W beats are not accepted.
- Throughput limits:
  - Reads and writes never overlap.
  - No outstanding transactions beyond one.
  - 4 KB-boundary crossing is not checked.

Decomposition:
- Package axi_pkg:
  - burst-type constants FIXED/INCR/WRAP;
  - resp constants OKAY/EXOKAY/SLVERR/DECERR;
  - state enum (IDLE, RD, WR, WR_RESP);
  - beat-size constant 4.
  - Shared with the cache AXI master.
- Sub-module axi_burst_addr_gen: combinational next-address from (addr, len, burst), instanced once and muxed between the read and write contexts.
- RAM is an inferred array inside the top module.

Test Plan:
1. Reset then idle: hold aresetn=0 for 2 cycles -> all valid/ready outputs 0 during reset; after release awready=1, arready=1, protocol_err=0.
2. INCR write then read: AW addr 0x40, len 7, id 3; 8 beats of 0x1000+i with wstrb F and wlast on beat 7 -> bvalid with bid=3, bresp=0. Then AR 0x40, len 7, rready=1 -> rvalid from the cycle after AR, 8 consecutive beats 0x1000..0x1007, rlast only on beat 7, rid matches arid.
3. Strobe/WRAP: write 0xAABBCCDD to 0x44 with wstrb 4'b0101, then WRAP read addr 0x48, len 3 -> rdata order [0x48],[0x4C],[0x40],[0x44]; the 0x44 beat shows only bytes 0 and 2 updated.
4. Backpressure: rready toggling 1,0,0,1 and bready held 0 for 5 cycles -> rdata/rvalid and bvalid/bid stay stable until handshake; no beat lost or repeated.
5. Simultaneous/erroneous: arvalid and awvalid asserted together -> write serviced first, read afterwards. Write len 7 with wlast on beat 8 (9th beat offered) -> burst ends after 8 beats, protocol_err=1, extra beat not accepted.
6. Out-of-range/mid-reset: read at BASE_ADDR + 2^(MEM_ADDR_LEN+2) -> rdata 0, rresp 2'b10. Reset asserted during beat 3 of a write -> FSM back to IDLE, beats 0-2 retained in RAM.

Source files
------------

// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - AXI burst/response encodings and responder state type
//
// Shared between the RAM responder and the cache AXI master.
//   BURST_*    : AxBURST encodings
//   RESP_*     : xRESP encodings
//   state_t    : responder FSM states
//   BEAT_BYTES : every beat moves one 32-bit word
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_WR_RESP
  } state_t;

  localparam logic [31:0] BEAT_BYTES = 32'd4;

endpackage

// File: rtl/axi_burst_addr_gen.sv
// rtl/axi_burst_addr_gen.sv - combinational next-beat address for AXI bursts
//
// Ports:
//   addr      in  32  address of the current beat
//   len       in   8  burst length minus one (AxLEN)
//   burst     in   2  burst type (AxBURST)
//   next_addr out 32  address of the following beat
module axi_burst_addr_gen (
  input  logic [31:0] addr,
  input  logic [7:0]  len,
  input  logic [1:0]  burst,
  output logic [31:0] next_addr
);
  import axi_pkg::*;

  logic [31:0] incr_addr;
  logic [31:0] wrap_mask;
  logic        wrap_ok;

  always_comb begin
    incr_addr = addr + BEAT_BYTES;
    wrap_ok   = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    // Window is (len+1)*4 bytes; with len = 2^n-1 this mask is window-1.
    wrap_mask = {22'd0, len, 2'b11};
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_WRAP:  next_addr = wrap_ok ? ((addr & ~wrap_mask) | (incr_addr & wrap_mask))
                                       : incr_addr;
      default:     next_addr = incr_addr;  // INCR and reserved 2'b11
    endcase
  end

endmodule

// File: rtl/axi_ram_slave.sv
// rtl/axi_ram_slave.sv - single-outstanding AXI3 burst responder over a word RAM
//
// Ports:
//   aclk, aresetn                         clock, synchronous active-low reset
//   ar* / arvalid / arready               read address channel (lock/cache/prot/size ignored)
//   rid/rdata/rresp/rlast/rvalid/rready   read data channel
//   aw* / awvalid / awready               write address channel (lock/cache/prot/size ignored)
//   wid/wdata/wstrb/wlast/wvalid/wready   write data channel (wid ignored)
//   bid/bresp/bvalid/bready               write response channel
//   protocol_err                          sticky: wlast disagreed with the beat count
module axi_ram_slave #(
  parameter int          MEM_ADDR_LEN = 12,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter              INIT_FILE    = ""
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic [1:0]  arlock,
  input  logic [3:0]  arcache,
  input  logic [2:0]  arprot,
  input  logic        arvalid,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic [1:0]  awlock,
  input  logic [3:0]  awcache,
  input  logic [2:0]  awprot,
  input  logic        awvalid,
  output logic        awready,
  input  logic [3:0]  wid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready,
  output logic        protocol_err
);
  import axi_pkg::*;

  localparam int DEPTH = 1 << MEM_ADDR_LEN;

  logic [31:0] mem [DEPTH];

  state_t      state;
  logic [3:0]  id_q;
  logic [31:0] cur_addr;
  logic [7:0]  len_q;
  logic [1:0]  burst_q;
  logic [7:0]  cnt;
  logic [1:0]  resp_acc;
  logic [31:0] next_addr;

  // Reads and writes never overlap, so one address register and one
  // generator serve whichever burst is active.
  axi_burst_addr_gen u_addr_gen (
    .addr      (cur_addr),
    .len       (len_q),
    .burst     (burst_q),
    .next_addr (next_addr)
  );

  logic ar_hs, aw_hs, r_hs, w_hs, b_hs;

  // awready is only high in IDLE; a pending write blocks the read so a
  // simultaneous pair is ordered write-then-read.
  assign arready = awready & ~awvalid;
  assign aw_hs   = awvalid & awready;
  assign ar_hs   = arvalid & arready;
  assign r_hs    = rvalid & rready;
  assign w_hs    = wvalid & wready;
  assign b_hs    = bvalid & bready;

  // Read port: beat 0 comes from araddr, later beats from the generator.
  logic [31:0]             rd_addr, rd_off, rd_word, wr_off;
  logic                    rd_ok, wr_ok, mem_we;
  logic [MEM_ADDR_LEN-1:0] rd_idx, wr_idx;

  assign rd_addr = (state == ST_IDLE) ? araddr : next_addr;
  assign rd_off  = rd_addr - BASE_ADDR;
  assign rd_ok   = (rd_off[31:MEM_ADDR_LEN+2] == '0);
  assign rd_idx  = rd_off[MEM_ADDR_LEN+1:2];
  assign rd_word = rd_ok ? mem[rd_idx] : 32'd0;

  assign wr_off  = cur_addr - BASE_ADDR;
  assign wr_ok   = (wr_off[31:MEM_ADDR_LEN+2] == '0);
  assign wr_idx  = wr_off[MEM_ADDR_LEN+1:2];
  // A beat presented in the same cycle as reset is abandoned, not written.
  assign mem_we  = aresetn & w_hs & wr_ok;

  always_ff @(posedge aclk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) mem[wr_idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state        <= ST_IDLE;
      awready      <= 1'b0;
      wready       <= 1'b0;
      rvalid       <= 1'b0;
      rlast        <= 1'b0;
      rid          <= 4'd0;
      rdata        <= 32'd0;
      rresp        <= RESP_OKAY;
      bvalid       <= 1'b0;
      bid          <= 4'd0;
      bresp        <= RESP_OKAY;
      protocol_err <= 1'b0;
      id_q         <= 4'd0;
      cur_addr     <= 32'd0;
      len_q        <= 8'd0;
      burst_q      <= BURST_INCR;
      cnt          <= 8'd0;
      resp_acc     <= RESP_OKAY;
    end else begin
      case (state)
        ST_IDLE: begin
          awready <= 1'b1;
          if (aw_hs) begin
            id_q     <= awid;
            cur_addr <= awaddr;
            len_q    <= awlen;
            burst_q  <= awburst;
            cnt      <= 8'd0;
            resp_acc <= RESP_OKAY;
            awready  <= 1'b0;
            wready   <= 1'b1;
            state    <= ST_WR;
          end else if (ar_hs) begin
            rid      <= arid;
            cur_addr <= araddr;
            len_q    <= arlen;
            burst_q  <= arburst;
            cnt      <= 8'd0;
            rdata    <= rd_word;
            rresp    <= rd_ok ? RESP_OKAY : RESP_SLVERR;
            rlast    <= (arlen == 8'd0);
            rvalid   <= 1'b1;
            awready  <= 1'b0;
            state    <= ST_RD;
          end
        end
        ST_RD: begin
          if (r_hs) begin
            if (rlast) begin
              rvalid  <= 1'b0;
              rlast   <= 1'b0;
              awready <= 1'b1;
              state   <= ST_IDLE;
            end else begin
              cur_addr <= next_addr;
              cnt      <= cnt + 8'd1;
              rdata    <= rd_word;
              rresp    <= rd_ok ? RESP_OKAY : RESP_SLVERR;
              rlast    <= (cnt + 8'd1 == len_q);
            end
          end
        end
        ST_WR: begin
          if (w_hs) begin
            if (wlast != (cnt == len_q)) protocol_err <= 1'b1;
            if (!wr_ok) resp_acc <= RESP_SLVERR;
            // The beat count, not wlast, decides where the burst ends.
            if (cnt == len_q) begin
              wready <= 1'b0;
              bvalid <= 1'b1;
              bid    <= id_q;
              bresp  <= wr_ok ? resp_acc : RESP_SLVERR;
              state  <= ST_WR_RESP;
            end else begin
              cur_addr <= next_addr;
              cnt      <= cnt + 8'd1;
            end
          end
        end
        ST_WR_RESP: begin
          if (b_hs) begin
            bvalid  <= 1'b0;
            awready <= 1'b1;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  logic unused;
  assign unused = ^{arsize, arlock, arcache, arprot, awsize, awlock, awcache, awprot,
                    wid, rd_off[1:0], wr_off[1:0]};

endmodule
